// File: rtl/dma_engine_if.sv
// dma_engine_if: shared 32-bit RAM bus between the DMA initiator and the arbitrated responder.
interface dma_engine_if;
  logic        gnt;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        re;
  logic        we;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  modport master (input gnt, rdata, output addr, wdata, re, we, wstrb);
  modport slave  (output gnt, rdata, input addr, wdata, re, we, wstrb);
endinterface

// File: rtl/dma_engine.sv
// dma_engine: word-granular copy/fill initiator with alignment and RAM window checks.
module dma_engine #(
  parameter int          LEN_W         = 16,
  parameter logic [31:0] RAM_BASE_ADDR = 32'h0001_0000,
  parameter logic [31:0] RAM_END_ADDR  = 32'h0001_4000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [31:0]      src,
  input  logic [31:0]      dst,
  input  logic [LEN_W-1:0] len,
  input  logic [31:0]      fill_val,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             err,
  dma_engine_if.master     bus
);
  typedef enum logic [2:0] {IDLE, CHECK, READ, WRITE, DONE} state_t;
  state_t state, state_nx;
  logic             md;
  logic [31:0]      sp, dp, dbuf;
  logic [LEN_W-1:0] cnt;
  logic [32:0]      dend, send;
  logic             bad;
  // 33-bit end addresses so a huge length cannot wrap back into the window
  assign dend = {1'b0, dp} + (33'(cnt) << 2);
  assign send = {1'b0, sp} + (33'(cnt) << 2);
  assign bad  = (cnt == '0) || (dp[1:0] != 2'b0) || (dp < RAM_BASE_ADDR) ||
                (dend > {1'b0, RAM_END_ADDR}) ||
                (!md && ((sp[1:0] != 2'b0) || (sp < RAM_BASE_ADDR) || (send > {1'b0, RAM_END_ADDR})));
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? CHECK : IDLE;
      CHECK:   state_nx = (abort || bad) ? DONE : (md ? WRITE : READ);
      READ:    state_nx = abort ? DONE : (bus.gnt ? WRITE : READ);
      WRITE:   state_nx = abort ? DONE : !bus.gnt ? WRITE : (cnt == LEN_W'(1)) ? DONE : (md ? WRITE : READ);
      default: state_nx = IDLE;
    endcase
  end
  assign busy      = (state == CHECK) || (state == READ) || (state == WRITE);
  assign done      = state == DONE;
  assign bus.re    = state == READ;
  assign bus.we    = state == WRITE;
  assign bus.wstrb = bus.we ? 4'hF : 4'h0;
  assign bus.addr  = bus.re ? sp : bus.we ? dp : 32'h0;
  assign bus.wdata = bus.we ? dbuf : 32'h0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      md    <= 1'b0;
      sp    <= '0;
      dp    <= '0;
      cnt   <= '0;
      dbuf  <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        md   <= mode;
        sp   <= src;
        dp   <= dst;
        cnt  <= len;
        dbuf <= fill_val;
        err  <= 1'b0;
      end
      if (state == READ && bus.gnt) begin
        dbuf <= bus.rdata;
        sp   <= sp + 32'd4;
      end
      if (state == WRITE && bus.gnt) begin
        dp  <= dp + 32'd4;
        cnt <= cnt - LEN_W'(1);
      end
      if ((busy && abort) || (state == CHECK && bad)) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_dma_engine.sv
// tb_dma_engine: randomized copy/fill commands against a word-level memory model of the engine.
module tb_dma_engine;
  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam logic [31:0] END_A = 32'h0001_4000;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, mode = 1'b0, abort = 1'b0;
  logic [31:0] src = '0, dst = '0, fill_val = '0;
  logic [15:0] len = '0;
  logic        busy, done, err;
  logic [31:0] mem [4096];
  logic [31:0] exp_mem [4096];
  int          vectors = 0, miscompares = 0;
  dma_engine_if bus();
  dma_engine #(.LEN_W(16), .RAM_BASE_ADDR(BASE), .RAM_END_ADDR(END_A)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .src(src), .dst(dst), .len(len),
    .fill_val(fill_val), .abort(abort), .busy(busy), .done(done), .err(err), .bus(bus)
  );
  always #5 clk = ~clk;
  assign bus.rdata = bus.re ? mem[bus.addr[13:2]] : 32'h0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  // the bench plays RAM responder: a granted write lands at the rising edge
  task automatic tick;
    logic        w;
    logic [31:0] a, wd;
    w  = bus.we && bus.gnt;
    a  = bus.addr;
    wd = bus.wdata;
    @(posedge clk);
    if (w) mem[a[13:2]] = wd;
    @(negedge clk);
  endtask
  function automatic bit in_win(input logic [31:0] a, input logic [15:0] n);
    return (a >= BASE) && (({1'b0, a} + 33'(n) * 33'd4) <= {1'b0, END_A});
  endfunction
  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2) & 4095;
  endfunction
  task automatic check_mem;
    int diffs = 0;
    foreach (mem[i]) if (mem[i] !== exp_mem[i]) diffs++;
    check("mem_diff", diffs, 0);
  endtask
  task automatic run_cmd(input logic m, input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                         input logic [31:0] fv, input int pct, input int stall_k, input int stall_n,
                         input int abort_k, input bit poke, output int dcyc);
    bit bad, fin, wr, g, aborted;
    int k, total, stalled, idx;
    logic [31:0] ea, ewd;
    bad   = (n == 0) || (d[1:0] != 0) || !in_win(d, n) || (!m && ((s[1:0] != 0) || !in_win(s, n)));
    total = bad ? 0 : (m ? int'(n) : 2 * int'(n));
    mode = m; src = s; dst = d; len = n; fill_val = fv; start = 1'b1; abort = 1'b0; bus.gnt = 1'b0;
    tick;
    start = 1'b0; src = $urandom; dst = $urandom; len = 16'($urandom); fill_val = $urandom; mode = 1'($urandom);
    check("chk_state", {busy, done, err, bus.re, bus.we}, 5'b10000);
    bus.gnt = 1'($urandom);
    tick;
    fin = bad; aborted = 1'b0; k = 0; stalled = 0; dcyc = -1;
    for (int c = 2; c < 2000; c++) begin
      if (fin) begin
        check("done_state", {busy, done, err, bus.re, bus.we}, {3'b010 | 3'(bad || aborted), 2'b00});
        check("done_addr", bus.addr, 0);
        dcyc = c; start = 1'b0; abort = 1'b0;
        tick;
        check("idle_after", {busy, done}, 2'b00);
        break;
      end
      wr  = m || (k % 2 == 1);
      idx = m ? k : k / 2;
      ea  = (wr ? d : s) + 32'(4 * idx);
      ewd = wr ? (m ? fv : exp_mem[(widx(s) + idx) & 4095]) : 32'h0;
      check("acc_ctl", {busy, done, bus.re, bus.we, bus.wstrb}, {2'b10, !wr, wr, {4{wr}}});
      check("acc_addr", bus.addr, ea);
      check("acc_wdata", bus.wdata, ewd);
      if (k == stall_k && stalled < stall_n) begin
        g = 1'b0;
        stalled++;
      end else g = (pct >= 100) || ($urandom_range(99) < pct);
      abort = (k == abort_k);
      if (poke) start = ($urandom_range(3) == 0);
      bus.gnt = g;
      tick;
      aborted = aborted || abort;
      abort = 1'b0;
      if (g) begin
        if (wr) exp_mem[(widx(d) + idx) & 4095] = ewd;
        k++;
      end
      if (aborted || k == total) fin = 1'b1;
    end
    if (dcyc < 0) check("done_timeout", 32'(k), 32'(total + 1));
    start = 1'b0;
    check_mem;
  endtask
  initial begin
    int dc, n;
    logic m;
    logic [31:0] s, d;
    foreach (mem[i]) mem[i] = $urandom;
    exp_mem = mem;
    bus.gnt = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ctl", {busy, done, err, bus.re, bus.we, bus.wstrb}, 0);
    check("rst_addr", bus.addr | bus.wdata, 0);
    rst_n = 1'b1;
    @(negedge clk);
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
    for (int i = 0; i < 4; i++) exp_mem[i] = mem[i];
    run_cmd(1'b0, BASE, BASE + 32'h100, 16'd4, 32'h0, 100, -1, 0, -1, 1'b0, dc);
    check("copy_cycle", dc, 10);
    for (int i = 0; i < 4; i++) check("copy_word", mem[64 + i], 32'(8'h11 * (i + 1)));
    run_cmd(1'b1, 32'h3, BASE + 32'h40, 16'd3, 32'hDEADBEEF, 100, -1, 0, -1, 1'b0, dc);
    check("fill_cycle", dc, 5);
    for (int i = 0; i < 3; i++) check("fill_word", mem[16 + i], 32'hDEADBEEF);
    run_cmd(1'b0, BASE + 32'h300, BASE + 32'h380, 16'd2, 32'h0, 100, 1, 3, -1, 1'b0, dc);
    check("stall_cycle", dc, 9);
    run_cmd(1'b1, 32'h0, BASE + 32'h2, 16'd1, 32'h5A5A5A5A, 100, -1, 0, -1, 1'b0, dc);
    check("rej_align", dc, 2);
    run_cmd(1'b0, BASE, BASE + 32'h500, 16'd0, 32'h0, 100, -1, 0, -1, 1'b0, dc);
    check("rej_len0", dc, 2);
    run_cmd(1'b1, 32'h0, END_A - 32'd4, 16'd2, 32'h12345678, 100, -1, 0, -1, 1'b0, dc);
    check("rej_range", dc, 2);
    run_cmd(1'b1, 32'h0, END_A - 32'd8, 16'd2, 32'h0F0F0F0F, 100, -1, 0, -1, 1'b0, dc);
    check("edge_range", dc, 4);
    run_cmd(1'b1, 32'h0, BASE + 32'h600, 16'd8, 32'hCAFEF00D, 100, -1, 0, 2, 1'b0, dc);
    check("abort_cycle", dc, 5);
    run_cmd(1'b1, 32'h0, BASE + 32'h700, 16'd2, 32'h600DF00D, 100, -1, 0, -1, 1'b0, dc);
    check("after_abort", dc, 4);
    mode = 1'b0; src = BASE; dst = BASE + 32'h200; len = 16'd4; start = 1'b1; bus.gnt = 1'b1;
    tick;
    start = 1'b0;
    repeat (2) tick;
    rst_n = 1'b0;
    #1;
    check("midrst_ctl", {busy, done, err, bus.re, bus.we, bus.wstrb}, 0);
    check("midrst_bus", bus.addr | bus.wdata, 0);
    @(negedge clk);
    repeat (2) begin
      tick;
      check("midrst_nodone", {busy, done}, 2'b00);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_mem;
    for (int t = 0; t < 40; t++) begin
      m = 1'($urandom);
      n = $urandom_range(1, 12);
      s = BASE + 32'(4 * $urandom_range(0, 4096 - n));
      d = BASE + 32'(4 * $urandom_range(0, 4096 - n));
      case ($urandom_range(9))
        0: d = d | 32'($urandom_range(1, 3));
        1: s = BASE - 32'd4;
        2: d = END_A - 32'(4 * n) + 32'd4;
        3: d = END_A - 32'(4 * n);
        4: n = 0;
        default: ;
      endcase
      run_cmd(m, s, d, 16'(n), $urandom, 70, -1, 0, ($urandom_range(7) == 0) ? int'($urandom_range(0, 5)) : -1, 1'b1, dc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
